// File: rtl/pc_seq_pkg.sv
// Shared types and default vectors for the PC sequencing controller.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        TRAP  = 3'd3,
        HALT  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        EXC    = 2'd1,
        BUSERR = 2'd2,
        ADDR   = 2'd3
    } cause_t;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0040_0000;
    localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h8000_0180;
    localparam int          DEF_ACK_TIMEOUT  = 16;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection: register jump, absolute jump, taken branch, or pc+4.
// All arithmetic wraps modulo 2^BIT_WIDTH.
module pc_next_mux #(
    parameter int BIT_WIDTH = 32
) (
    input  logic [BIT_WIDTH-1:0] pc_cur,
    input  logic                 is_jr,
    input  logic                 is_jump,
    input  logic                 is_branch,
    input  logic                 branch_cond,
    input  logic [BIT_WIDTH-1:0] jr_target,
    input  logic [15:0]          imm16,
    input  logic [25:0]          jtarget,
    output logic [BIT_WIDTH-1:0] pc_next
);

    logic [BIT_WIDTH-1:0] pc4;
    logic [BIT_WIDTH-1:0] br_off;

    assign pc4    = pc_cur + BIT_WIDTH'(4);
    assign br_off = {{(BIT_WIDTH-18){imm16[15]}}, imm16, 2'b00};

    // NOTE: every branch of this chain assigns pc_next; a missing else would infer a latch.
    always_comb begin
        if (is_jr)
            pc_next = jr_target;
        else if (is_jump)
            pc_next = {pc4[BIT_WIDTH-1:28], jtarget, 2'b00};
        else if (is_branch && branch_cond)
            pc_next = pc4 + br_off;
        else
            pc_next = pc4;
    end

endmodule

// File: rtl/pc_seq_ctrl.sv
// PC sequencing controller: fetch handshake, next-PC write and halt.
// Trap support (EXC, fetch timeout, misaligned jr) exists only with PC_SEQ_TRAP_EN defined.
module pc_seq_ctrl
    import pc_seq_pkg::*;
#(
    parameter int                   BIT_WIDTH    = 32,
    parameter logic [BIT_WIDTH-1:0] RESET_VECTOR = BIT_WIDTH'(DEF_RESET_VECTOR),
    parameter logic [BIT_WIDTH-1:0] TRAP_VECTOR  = BIT_WIDTH'(DEF_TRAP_VECTOR),
    parameter int                   ACK_TIMEOUT  = DEF_ACK_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BIT_WIDTH-1:0] pc_cur,
    output logic [BIT_WIDTH-1:0] pc_next,
    output logic                 pc_en,
    output logic                 imem_req,
    input  logic                 imem_ack,
    input  logic                 is_branch,
    input  logic                 branch_cond,
    input  logic                 is_jump,
    input  logic                 is_jr,
    input  logic                 stall,
    input  logic                 halt_req,
    input  logic                 exc_req,
    input  logic [BIT_WIDTH-1:0] rs_data,
    input  logic [15:0]          imm16,
    input  logic [25:0]          jtarget,
    output logic [BIT_WIDTH-1:0] epc,
    output logic [1:0]           cause,
    output logic                 halted
);

    state_t               state;
    logic [BIT_WIDTH-1:0] jr_target;
    logic [BIT_WIDTH-1:0] mux_next;
    logic                 trap_go;
    logic                 exec_write;
    logic                 unused_ok;

`ifdef PC_SEQ_TRAP_EN
    localparam int               CNT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    logic [CNT_W-1:0]     ack_wait;
    logic [BIT_WIDTH-1:0] epc_q;
    cause_t               cause_q;
    cause_t               trap_cause;
    logic                 jr_misaligned;

    assign jr_target     = rs_data;
    assign jr_misaligned = is_jr && (rs_data[1:0] != 2'b00);
    assign exec_write    = !exc_req && !stall && !halt_req && !jr_misaligned;
    assign epc           = epc_q;
    assign cause         = cause_q;
    assign unused_ok     = ^RESET_VECTOR;

    // Trap priority in EXEC: exc_req beats stall; misaligned jr only when the PC would be written.
    always_comb begin
        trap_go    = 1'b0;
        trap_cause = NONE;
        if (state == FETCH && !imem_ack && ack_wait == CNT_LAST) begin
            trap_go    = 1'b1;
            trap_cause = BUSERR;
        end else if (state == EXEC) begin
            if (exc_req) begin
                trap_go    = 1'b1;
                trap_cause = EXC;
            end else if (!stall && !halt_req && jr_misaligned) begin
                trap_go    = 1'b1;
                trap_cause = ADDR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ack_wait <= '0;
            epc_q    <= '0;
            cause_q  <= NONE;
        end else begin
            if (state == FETCH && !imem_ack && !trap_go)
                ack_wait <= ack_wait + CNT_W'(1);
            else
                ack_wait <= '0;
            if (trap_go)
                cause_q <= trap_cause;
            if (state == TRAP)
                epc_q <= pc_cur;
        end
    end
`else
    // Without traps a misaligned jr target is silently word-aligned.
    assign jr_target  = {rs_data[BIT_WIDTH-1:2], 2'b00};
    assign trap_go    = 1'b0;
    assign exec_write = !stall && !halt_req;
    assign epc        = '0;
    assign cause      = 2'b00;
    assign unused_ok  = ^{RESET_VECTOR, exc_req, rs_data[1:0], 1'(ACK_TIMEOUT)};
`endif

    pc_next_mux #(.BIT_WIDTH(BIT_WIDTH)) u_mux (
        .pc_cur      (pc_cur),
        .is_jr       (is_jr),
        .is_jump     (is_jump),
        .is_branch   (is_branch),
        .branch_cond (branch_cond),
        .jr_target   (jr_target),
        .imm16       (imm16),
        .jtarget     (jtarget),
        .pc_next     (mux_next)
    );

    // Outputs are gated by rst so nothing is requested or written while reset is held.
    always_comb begin
        imem_req = 1'b0;
        pc_en    = 1'b0;
        pc_next  = mux_next;
        if (rst) begin
            case (state)
                FETCH: imem_req = 1'b1;
                EXEC:  pc_en    = exec_write;
                TRAP: begin
                    pc_en   = 1'b1;
                    pc_next = TRAP_VECTOR;
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            halted <= 1'b0;
        end else begin
            case (state)
                IDLE:  state <= FETCH;
                FETCH: begin
                    if (imem_ack)
                        state <= EXEC;
                    else if (trap_go)
                        state <= TRAP;
                end
                EXEC: begin
                    if (trap_go)
                        state <= TRAP;
                    else if (stall)
                        state <= EXEC;
                    else if (halt_req) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else
                        state <= FETCH;
                end
                TRAP:    state <= FETCH;
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: directed scenarios plus randomized traffic
// against a transaction-level reference model. Honors PC_SEQ_TRAP_EN like the design.
module tb_pc_seq_ctrl;

    localparam logic [31:0] RV      = 32'h0040_0000;
    localparam logic [31:0] TV      = 32'h8000_0180;
    localparam int          TIMEOUT = 16;
`ifdef PC_SEQ_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum {M_IDLE, M_FETCH, M_EXEC, M_TRAP, M_HALT} mode_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_cur, pc_next, rs_data, epc;
    logic        pc_en, imem_req, imem_ack;
    logic        is_branch, branch_cond, is_jump, is_jr, stall, halt_req, exc_req;
    logic [15:0] imm16;
    logic [25:0] jtarget;
    logic [1:0]  cause;
    logic        halted;

    // External PC register, owned by the bench
    logic [31:0] pc_reg, pc_pend;
    assign pc_cur = pc_reg;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    mode_t       m;
    int          waited;
    logic [31:0] m_epc;
    logic [1:0]  m_cause;

    pc_seq_ctrl #(
        .BIT_WIDTH    (32),
        .RESET_VECTOR (RV),
        .TRAP_VECTOR  (TV),
        .ACK_TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_cur      (pc_cur),
        .pc_next     (pc_next),
        .pc_en       (pc_en),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .is_branch   (is_branch),
        .branch_cond (branch_cond),
        .is_jump     (is_jump),
        .is_jr       (is_jr),
        .stall       (stall),
        .halt_req    (halt_req),
        .exc_req     (exc_req),
        .rs_data     (rs_data),
        .imm16       (imm16),
        .jtarget     (jtarget),
        .epc         (epc),
        .cause       (cause),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        imem_ack = 1'b0; is_branch = 1'b0; branch_cond = 1'b0; is_jump = 1'b0;
        is_jr = 1'b0; stall = 1'b0; halt_req = 1'b0; exc_req = 1'b0;
        rs_data = '0; imm16 = '0; jtarget = '0;
    endtask

    // Target address computed straight from the addressing rules
    function automatic logic [31:0] ref_target();
        logic [31:0] pc4;
        int off;
        pc4 = pc_reg + 32'd4;
        if (is_jr) return TRAP_EN ? rs_data : (rs_data & 32'hFFFF_FFFC);
        if (is_jump) return (pc4 & 32'hF000_0000) | ({6'd0, jtarget} * 32'd4);
        if (is_branch && branch_cond) begin
            off = $signed(imm16);
            return pc4 + 32'(off * 4);
        end
        return pc4;
    endfunction

    function automatic bit ref_exec_writes();
        if (TRAP_EN && exc_req) return 1'b0;
        if (stall || halt_req) return 1'b0;
        if (TRAP_EN && is_jr && (rs_data % 4 != 0)) return 1'b0;
        return 1'b1;
    endfunction

    // One clock: inputs were set at the preceding negedge; check outputs, advance the model.
    task automatic cycle();
        logic        exp_req, exp_en;
        logic [31:0] exp_next;
        #1;
        exp_req  = rst && (m == M_FETCH);
        exp_en   = 1'b0;
        exp_next = '0;
        if (rst && m == M_TRAP) begin
            exp_en   = 1'b1;
            exp_next = TV;
        end
        if (rst && m == M_EXEC && ref_exec_writes()) begin
            exp_en   = 1'b1;
            exp_next = ref_target();
        end
        check("imem_req", imem_req, exp_req);
        check("pc_en", pc_en, exp_en);
        if (exp_en) check("pc_next", pc_next, exp_next);
        check("halted", halted, m == M_HALT);
        check("epc", epc, m_epc);
        check("cause", cause, m_cause);

        @(posedge clk);
        pc_pend = exp_en ? exp_next : pc_reg;
        if (!rst) begin
            m = M_IDLE; waited = 0; m_epc = '0; m_cause = '0; pc_pend = RV;
        end else begin
            case (m)
                M_IDLE: begin m = M_FETCH; waited = 0; end
                M_FETCH: begin
                    if (imem_ack) m = M_EXEC;
                    else if (TRAP_EN) begin
                        waited++;
                        if (waited == TIMEOUT) begin m = M_TRAP; m_cause = 2'd2; end
                    end
                end
                M_EXEC: begin
                    if (TRAP_EN && exc_req) begin m = M_TRAP; m_cause = 2'd1; end
                    else if (stall) m = M_EXEC;
                    else if (halt_req) m = M_HALT;
                    else if (TRAP_EN && is_jr && (rs_data % 4 != 0)) begin m = M_TRAP; m_cause = 2'd3; end
                    else begin m = M_FETCH; waited = 0; end
                end
                M_TRAP: begin m_epc = pc_reg; m = M_FETCH; waited = 0; end
                default: m = M_HALT;
            endcase
        end
        @(negedge clk);
        pc_reg = pc_pend;
    endtask

    // From FETCH: acknowledge the fetch and land in EXEC
    task automatic to_exec();
        imem_ack = 1'b1;
        cycle();
        imem_ack = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0; pc_reg = RV; pc_pend = RV;
        m = M_IDLE; waited = 0; m_epc = '0; m_cause = '0;
        @(negedge clk);

        // Reset held, then release: one IDLE cycle, two unacked fetch cycles, ack
        imem_ack = 1'b1;
        cycle();
        rst = 1'b1; imem_ack = 1'b0;
        #1;
        check("idle_pc_en", pc_en, 1'b0);
        check("idle_req", imem_req, 1'b0);
        cycle();
        cycle();
        cycle();
        to_exec();
        #1;
        check("seq_en", pc_en, 1'b1);
        check("seq_next", pc_next, 32'h0040_0004);
        cycle();

        // Branch taken backward by one word, then not taken
        pc_reg = 32'h0040_0010;
        to_exec();
        is_branch = 1'b1; branch_cond = 1'b1; imm16 = 16'hFFFF;
        #1;
        check("br_taken", pc_next, 32'h0040_0010);
        cycle();
        clear_inputs();
        to_exec();
        is_branch = 1'b1; branch_cond = 1'b0; imm16 = 16'hFFFF;
        #1;
        check("br_not_taken", pc_next, 32'h0040_0014);
        cycle();
        clear_inputs();

        // jr outranks jump; then misaligned jr
        to_exec();
        is_jr = 1'b1; is_jump = 1'b1; jtarget = 26'h3FF_FFFF; rs_data = 32'h0040_0100;
        #1;
        check("jr_prio", pc_next, 32'h0040_0100);
        cycle();
        to_exec();
        rs_data = 32'h0040_0102;
`ifdef PC_SEQ_TRAP_EN
        #1;
        check("jr_mis_no_write", pc_en, 1'b0);
        cycle();
        clear_inputs();
        #1;
        check("jr_mis_cause", cause, 2'd3);
        check("trap_en", pc_en, 1'b1);
        check("trap_vec", pc_next, 32'h8000_0180);
        cycle();
        #1;
        check("jr_mis_epc", epc, 32'h0040_0100);
`else
        #1;
        check("jr_mis_aligned", pc_next, 32'h0040_0100);
        cycle();
        clear_inputs();
`endif

        // Sequential wrap at the top of the address space
        pc_reg = 32'hFFFF_FFFC;
        to_exec();
        #1;
        check("wrap", pc_next, 32'h0000_0000);
        cycle();

        // Stall holds the PC; exc_req beats stall
        to_exec();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_no_write", pc_en, 1'b0);
            cycle();
        end
        exc_req = 1'b1;
        cycle();
        clear_inputs();
`ifdef PC_SEQ_TRAP_EN
        #1;
        check("exc_cause", cause, 2'd1);
        check("exc_trap_en", pc_en, 1'b1);
        cycle();
`else
        cycle();
`endif

        // Fetch with no ack
`ifdef PC_SEQ_TRAP_EN
        repeat (TIMEOUT - 1) cycle();
        #1;
        check("tmo_last_wait", pc_en, 1'b0);
        cycle();
        #1;
        check("tmo_cause", cause, 2'd2);
        check("tmo_trap_en", pc_en, 1'b1);
        cycle();
`else
        repeat (TIMEOUT + 4) cycle();
        #1;
        check("tmo_still_req", imem_req, 1'b1);
        check("tmo_no_write", pc_en, 1'b0);
`endif

        // Reset mid-fetch with a late ack
        rst = 1'b0; imem_ack = 1'b1;
        cycle();
        rst = 1'b1;
        cycle();
        imem_ack = 1'b0;
        #1;
        check("rst_fetch_req", imem_req, 1'b1);
        check("rst_fetch_en", pc_en, 1'b0);
        cycle();

        // Halt is terminal until reset
        to_exec();
        halt_req = 1'b1;
        cycle();
        halt_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            imem_ack = 1'($urandom); stall = 1'($urandom); exc_req = 1'($urandom);
            cycle();
        end
        #1;
        check("halt_flag", halted, 1'b1);
        check("halt_req_off", imem_req, 1'b0);
        clear_inputs();
        rst = 1'b0;
        cycle();
        rst = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) != 0);
            if (m == M_HALT && $urandom_range(0, 7) == 0) rst = 1'b0;
            imem_ack    = ($urandom_range(0, 2) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            exc_req     = ($urandom_range(0, 15) == 0);
            halt_req    = ($urandom_range(0, 63) == 0);
            is_jr       = ($urandom_range(0, 3) == 0);
            is_jump     = ($urandom_range(0, 3) == 0);
            is_branch   = ($urandom_range(0, 1) == 0);
            branch_cond = 1'($urandom);
            rs_data     = $urandom;
            if ($urandom_range(0, 3) != 0) rs_data[1:0] = 2'b00;
            imm16       = 16'($urandom);
            jtarget     = 26'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
